// File: rtl/draw_canvas_pkg.sv
// draw_canvas_pkg: shared FSM states, scan codes, raster colours and intensity helpers
// for the drawing-canvas controller.
package draw_canvas_pkg;
   localparam logic [2:0] ST_INIT     = 3'd0;
   localparam logic [2:0] ST_CLEAR    = 3'd1;
   localparam logic [2:0] ST_READY    = 3'd2;
   localparam logic [2:0] ST_COOLDOWN = 3'd3;
   localparam logic [2:0] ST_BRUSH    = 3'd4;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;
   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [2:0] COL_CURSOR = 3'b100;
   localparam logic [2:0] COL_HIGH   = 3'b111;
   localparam logic [2:0] COL_LOW    = 3'b010;
   localparam logic [2:0] COL_EMPTY  = 3'b001;
   function automatic int unsigned full_val(input int unsigned w);
      return (1 << w) - 1;
   endfunction
   function automatic int unsigned half_val(input int unsigned w);
      return 1 << (w - 1);
   endfunction
endpackage

// File: rtl/canvas_ram.sv
// canvas_ram: canvas intensity store, one write port and three registered read ports;
// a read of the cell being written returns the old data.
module canvas_ram #(
   parameter int DEPTH = 784,
   parameter int AW = 10,
   parameter int DW = 8
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] ras_addr,
   input  logic [AW-1:0] nn_addr,
   input  logic [AW-1:0] br_addr,
   output logic [DW-1:0] ras_data,
   output logic [DW-1:0] nn_data,
   output logic [DW-1:0] br_data
);
   logic [DW-1:0] mem [DEPTH];
   always_ff @(posedge CLOCK_50) begin
      if (we) mem[wr_addr] <= wr_data;
      ras_data <= mem[ras_addr];
      br_data <= mem[br_addr];
   end
   // Only the inference port has a defined reset value.
   always_ff @(posedge CLOCK_50)
      nn_data <= reset ? '0 : mem[nn_addr];
endmodule

// File: rtl/draw_canvas_ctrl.sv
// draw_canvas_ctrl: cursor-driven drawing canvas with a VGA raster and an inference read port.
// Define SOFT_BRUSH_EN to spread each stroke into its N/S/W/E neighbours.
module draw_canvas_ctrl
   import draw_canvas_pkg::*;
#(
   parameter int GRID_W = 28,
   parameter int GRID_H = 28,
   parameter int CELL_LOG2 = 2,
   parameter int DATA_W = 8,
   parameter int MOVE_DELAY = 2000000,
   localparam int N = GRID_W * GRID_H,
   localparam int AW = $clog2(N),
   localparam int XW = $clog2(GRID_W),
   localparam int YW = $clog2(GRID_H)
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              enable,
   input  logic              key_valid,
   input  logic [7:0]        key_code,
   input  logic              draw,
   input  logic              erase,
   input  logic              clear,
   input  logic [AW-1:0]     nn_rd_addr,
   output logic [DATA_W-1:0] nn_rd_data,
   output logic [XW-1:0]     cursor_x,
   output logic [YW-1:0]     cursor_y,
   output logic              busy,
   output logic [7:0]        vga_x,
   output logic [6:0]        vga_y,
   output logic [2:0]        vga_colour,
   output logic              vga_plot
);
   localparam logic [DATA_W-1:0] FULL = DATA_W'(full_val(DATA_W));
   localparam logic [DATA_W-1:0] HALF = DATA_W'(half_val(DATA_W));
   localparam int PW = GRID_W << CELL_LOG2;
   localparam int PH = GRID_H << CELL_LOG2;
   localparam int CW = $clog2(MOVE_DELAY + 2);
   function automatic logic [AW-1:0] addr_of(input logic [31:0] x, input logic [31:0] y);
      return AW'(y * GRID_W + x);
   endfunction
   logic [2:0] state;
   logic [AW-1:0] clr_addr, cur_addr, ras_addr, wr_addr, br_addr;
   logic [CW-1:0] cool;
   logic we;
   logic [DATA_W-1:0] wr_data, ras_data, br_data;
   logic go_l, go_r, go_u, go_d, mv_ok, brush_go;
   logic [7:0] px, s1_x;
   logic [6:0] py, s1_y;
   logic s1_cur, s1_vld;
   assign cur_addr = addr_of(32'(cursor_x), 32'(cursor_y));
   assign ras_addr = addr_of(32'(px >> CELL_LOG2), 32'(py >> CELL_LOG2));
   assign busy = state == ST_CLEAR || state == ST_BRUSH;
   assign go_l = key_valid && key_code == KEY_LEFT && cursor_x != '0;
   assign go_r = key_valid && key_code == KEY_RIGHT && cursor_x != XW'(GRID_W - 1);
   assign go_u = key_valid && key_code == KEY_UP && cursor_y != '0;
   assign go_d = key_valid && key_code == KEY_DOWN && cursor_y != YW'(GRID_H - 1);
   assign mv_ok = go_l | go_r | go_u | go_d;
`ifdef SOFT_BRUSH_EN
   logic [3:0] nb_mask, nb_init;
   logic nb_phase, nb_last;
   logic [AW-1:0] nb_addr;
   logic [DATA_W:0] nb_sum;
   // Bit order N, S, W, E: the lowest set bit is the neighbour being visited.
   assign nb_init = {cursor_x != XW'(GRID_W - 1), cursor_x != '0, cursor_y != YW'(GRID_H - 1), cursor_y != '0};
   assign nb_addr = nb_mask[0] ? cur_addr - AW'(GRID_W) :
                    nb_mask[1] ? cur_addr + AW'(GRID_W) :
                    nb_mask[2] ? cur_addr - AW'(1) : cur_addr + AW'(1);
   assign nb_last = (nb_mask & (nb_mask - 4'd1)) == 4'd0;
   assign nb_sum = {1'b0, br_data} + {1'b0, HALF};
   assign brush_go = !clear && !erase && draw && nb_init != 4'd0;
   assign br_addr = nb_addr;
   always_ff @(posedge CLOCK_50)
      if (reset) begin
         nb_mask <= '0;
         nb_phase <= 1'b0;
      end else if (enable && state == ST_READY && brush_go) begin
         nb_mask <= nb_init;
         nb_phase <= 1'b0;
      end else if (enable && state == ST_BRUSH) begin
         nb_phase <= !nb_phase;
         if (nb_phase) nb_mask <= nb_mask & (nb_mask - 4'd1);
      end
`else
   logic unused;
   assign unused = ^br_data;
   assign brush_go = 1'b0;
   assign br_addr = '0;
`endif
   always_comb begin
      we = 1'b0;
      wr_addr = cur_addr;
      wr_data = '0;
      if (enable) begin
         if (state == ST_CLEAR) begin
            we = 1'b1;
            wr_addr = clr_addr;
         end else if ((state == ST_READY && !clear) || state == ST_COOLDOWN) begin
            we = erase | draw;
            wr_data = erase ? '0 : FULL;
`ifdef SOFT_BRUSH_EN
         end else if (state == ST_BRUSH) begin
            we = nb_phase;
            wr_addr = nb_addr;
            wr_data = nb_sum[DATA_W] ? FULL : nb_sum[DATA_W-1:0];
`endif
         end
      end
   end
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state <= ST_INIT;
         clr_addr <= '0;
         cursor_x <= '0;
         cursor_y <= '0;
         cool <= '0;
      end else if (enable) begin
         case (state)
            ST_INIT: begin
               clr_addr <= '0;
               state <= ST_CLEAR;
            end
            ST_CLEAR: begin
               clr_addr <= clr_addr + AW'(1);
               if (clr_addr == AW'(N - 1)) state <= ST_READY;
            end
            ST_READY:
               if (clear) begin
                  clr_addr <= '0;
                  state <= ST_CLEAR;
               end else if (brush_go) state <= ST_BRUSH;
               else if (mv_ok) begin
                  cursor_x <= cursor_x + XW'(go_r) - XW'(go_l);
                  cursor_y <= cursor_y + YW'(go_d) - YW'(go_u);
                  cool <= CW'(MOVE_DELAY);
                  state <= ST_COOLDOWN;
               end
            ST_COOLDOWN:
               if (cool == '0) state <= ST_READY;
               else cool <= cool - CW'(1);
`ifdef SOFT_BRUSH_EN
            ST_BRUSH:
               if (nb_phase && nb_last) state <= ST_READY;
`endif
            default: state <= ST_INIT;
         endcase
      end
   end
   // Stage 1 issues the cell read; stage 2 pairs the returned data with its pixel.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         px <= '0;
         py <= '0;
         s1_x <= '0;
         s1_y <= '0;
         s1_cur <= 1'b0;
         s1_vld <= 1'b0;
         vga_x <= '0;
         vga_y <= '0;
         vga_colour <= COL_EMPTY;
         vga_plot <= 1'b0;
      end else begin
         vga_plot <= enable && s1_vld;
         if (enable) begin
            px <= px == 8'(PW - 1) ? '0 : px + 8'd1;
            py <= px != 8'(PW - 1) ? py : py == 7'(PH - 1) ? '0 : py + 7'd1;
            s1_x <= px;
            s1_y <= py;
            s1_cur <= ras_addr == cur_addr;
            s1_vld <= 1'b1;
            vga_x <= s1_x;
            vga_y <= s1_y;
            vga_colour <= s1_cur ? COL_CURSOR : ras_data >= HALF ? COL_HIGH :
                          ras_data != '0 ? COL_LOW : COL_EMPTY;
         end
      end
   end
   canvas_ram #(.DEPTH(N), .AW(AW), .DW(DATA_W)) u_ram (
      .CLOCK_50(CLOCK_50),
      .reset(reset),
      .we(we),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .ras_addr(ras_addr),
      .nn_addr(nn_rd_addr),
      .br_addr(br_addr),
      .ras_data(ras_data),
      .nn_data(nn_rd_data),
      .br_data(br_data)
   );
endmodule
